next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 140 ++++++++++++++
 tb/tb_next_pc_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// ---------------------------------------------------------------------------
// next_pc_unit
//
// Purpose:
//   Holds the fetch program counter and chooses the next fetch address.
//   The next address is one of three things: a sequential step, a
//   relative branch or jump, or a register-indirect target. A redirect
//   that arrives while fetch is stalled is kept in a one-entry buffer. It
//   is applied on the next advancing edge.
//
// Ports:
//   clock            in   rising-edge clock for all state
//   reset            in   synchronous, active-high reset
//   update_en        in   a retiring instruction presents a PC update
//   select_pc[1:0]   in   00 seq, 01 cond branch, 10 jump, 11 reg-indirect
//   branch_taken     in   branch condition (used only with select_pc=01)
//   imm_14bit[13:0]  in   branch halfword offset
//   imm_24bit[23:0]  in   jump halfword offset
//   reg_rb_data      in   register-indirect target (DataSize bits)
//   fetch_ready      in   instruction memory accepts current_pc this cycle
//   current_pc       out  registered fetch address
//   fetch_valid      out  current_pc is a valid fetch request
//   link_pc          out  current_pc + InstBytes (combinational, wraps)
//   redirect_pending out  a redirect is buffered, awaiting fetch_ready
// ---------------------------------------------------------------------------
module next_pc_unit #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataSize  = 32,
    parameter int unsigned ResetPc   = 0,
    parameter int unsigned InstBytes = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 update_en,
    input  logic [1:0]           select_pc,
    input  logic                 branch_taken,
    input  logic [13:0]          imm_14bit,
    input  logic [23:0]          imm_24bit,
    input  logic [DataSize-1:0]  reg_rb_data,
    input  logic                 fetch_ready,
    output logic [AddrWidth-1:0] current_pc,
    output logic                 fetch_valid,
    output logic [AddrWidth-1:0] link_pc,
    output logic                 redirect_pending
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [AddrWidth-1:0] ResetPcVal = AddrWidth'(ResetPc);
    localparam logic [AddrWidth-1:0] StepVal    = AddrWidth'(InstBytes);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic                 pending_q, pending_d;
    logic [AddrWidth-1:0] pending_pc_q, pending_pc_d;

    logic [AddrWidth-1:0] branch_off;
    logic [AddrWidth-1:0] jump_off;
    logic [AddrWidth-1:0] indirect_pc;
    logic [AddrWidth-1:0] redirect_target;
    logic                 redirect_req;
    logic                 advance;

    // The register-indirect target uses only the low address bits.
    // Bit 0 is forced to zero, so that bit is not needed either.
    logic unused_rb_bits;
    assign unused_rb_bits = ^{reg_rb_data[DataSize-1:AddrWidth], reg_rb_data[0]};

    // Each offset is a halfword count. It is shifted left by one and then
    // sign-extended or truncated to the PC width. Any overflow in the add
    // wraps silently.
    assign branch_off  = AddrWidth'($signed({imm_14bit, 1'b0}));
    assign jump_off    = AddrWidth'($signed({imm_24bit, 1'b0}));
    assign indirect_pc = {reg_rb_data[AddrWidth-1:1], 1'b0};

    assign current_pc       = pc_q;
    assign fetch_valid      = (state_q == RUN);
    assign link_pc          = pc_q + StepVal;
    assign redirect_pending = pending_q;

    // A not-taken branch counts as a sequential update, not a redirect.
    assign redirect_req = update_en &&
                          ((select_pc == 2'b10) || (select_pc == 2'b11) ||
                           ((select_pc == 2'b01) && branch_taken));

    assign advance = fetch_valid && fetch_ready;

    always_comb begin
        redirect_target = link_pc;
        unique case (select_pc)
            2'b01:   redirect_target = pc_q + branch_off;
            2'b10:   redirect_target = pc_q + jump_off;
            2'b11:   redirect_target = indirect_pc;
            default: redirect_target = link_pc;
        endcase
    end

    // BOOT lasts exactly one cycle after reset is released. On an advancing
    // edge, a same-cycle redirect wins over the buffered one. The newer
    // request is the more recent program-order decision, so the buffer is
    // dropped. A request that arrives while stalled overwrites the buffer.
    always_comb begin
        state_d      = RUN;
        pc_d         = pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;

        if (advance) begin
            pending_d = 1'b0;
            if (redirect_req) begin
                pc_d = redirect_target;
            end else if (pending_q) begin
                pc_d = pending_pc_q;
            end else begin
                pc_d = link_pc;
            end
        end else if (redirect_req) begin
            pending_d    = 1'b1;
            pending_pc_d = redirect_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= ResetPcVal;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_next_pc_unit
//
// Testbench for next_pc_unit with AddrWidth=10, ResetPc=0 and InstBytes=4.
// It runs a table of directed vectors, then hand-written reset and stall
// sequences, then randomized traffic checked against a reference model.
// ---------------------------------------------------------------------------
module tb_next_pc_unit;

    localparam int AW   = 10;
    localparam int MASK = (1 << AW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          update_en;
    logic [1:0]    select_pc;
    logic          branch_taken;
    logic [13:0]   imm_14bit;
    logic [23:0]   imm_24bit;
    logic [31:0]   reg_rb_data;
    logic          fetch_ready;
    logic [AW-1:0] current_pc;
    logic          fetch_valid;
    logic [AW-1:0] link_pc;
    logic          redirect_pending;

    int numCompared   = 0;
    int numMismatched = 0;

    // Reference model state, kept as plain integers.
    int mPc;
    int mPendPc;
    bit mPend;
    bit mBoot;

    always #5 clock = ~clock;

    next_pc_unit #(
        .AddrWidth(AW),
        .DataSize (32),
        .ResetPc  (0),
        .InstBytes(4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .update_en       (update_en),
        .select_pc       (select_pc),
        .branch_taken    (branch_taken),
        .imm_14bit       (imm_14bit),
        .imm_24bit       (imm_24bit),
        .reg_rb_data     (reg_rb_data),
        .fetch_ready     (fetch_ready),
        .current_pc      (current_pc),
        .fetch_valid     (fetch_valid),
        .link_pc         (link_pc),
        .redirect_pending(redirect_pending)
    );

    typedef struct {
        logic        ue;
        logic [1:0]  sel;
        logic        tk;
        logic [13:0] i14;
        logic [23:0] i24;
        logic [31:0] rb;
        logic        rdy;
        int          expPc;
        logic        expPend;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input int actual, input int expected);
        numCompared++;
        if (actual != expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input int expPc, input bit expPend, input bit expValid);
        checkOutput({tag, " pc"}, int'(current_pc), expPc);
        checkOutput({tag, " pending"}, int'(redirect_pending), int'(expPend));
        checkOutput({tag, " fetch_valid"}, int'(fetch_valid), int'(expValid));
        checkOutput({tag, " link_pc"}, int'(link_pc), (expPc + 4) & MASK);
    endtask

    // Drives one cycle of inputs, advances the model by the same cycle,
    // and returns 1 ns after the rising edge so the outputs have settled.
    task automatic applyStimulus(input logic rst, input logic ue, input logic [1:0] sel,
                                 input logic tk, input logic [13:0] i14, input logic [23:0] i24,
                                 input logic [31:0] rb, input logic rdy);
        int  s14;
        int  s24;
        int  tgt;
        bit  req;
        bit  adv;
        reset        = rst;
        update_en    = ue;
        select_pc    = sel;
        branch_taken = tk;
        imm_14bit    = i14;
        imm_24bit    = i24;
        reg_rb_data  = rb;
        fetch_ready  = rdy;

        s14 = i14[13] ? int'(i14) - (1 << 14) : int'(i14);
        s24 = i24[23] ? int'(i24) - (1 << 24) : int'(i24);
        req = ue && (sel == 2'd2 || sel == 2'd3 || (sel == 2'd1 && tk));
        if (sel == 2'd1)      tgt = (mPc + 2 * s14) & MASK;
        else if (sel == 2'd2) tgt = (mPc + 2 * s24) & MASK;
        else                  tgt = int'(rb % 1024) & ~1;
        adv = !mBoot && rdy;

        if (rst) begin
            mPc = 0; mBoot = 1; mPend = 0; mPendPc = 0;
        end else begin
            if (adv) begin
                if (req)        mPc = tgt;
                else if (mPend) mPc = mPendPc;
                else            mPc = (mPc + 4) & MASK;
                mPend = 0;
            end else if (req) begin
                mPend   = 1;
                mPendPc = tgt;
            end
            mBoot = 0;
        end

        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b1, 'h00C, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b1, 'h010, 1'b0};
        vecs[2]  = '{1'b1, 2'd1, 1'b1, 14'h3FFC, 24'h000000, 32'h0,    1'b1, 'h008, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b1, 'h00C, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b1, 'h010, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 14'h3FFC, 24'h000000, 32'h0,    1'b1, 'h014, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 14'h0000, 24'h000010, 32'h0,    1'b1, 'h034, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 14'h0000, 24'h000000, 32'h1235, 1'b1, 'h234, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 14'h0000, 24'h000010, 32'h0,    1'b0, 'h234, 1'b1};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 14'h0000, 24'h000000, 32'h0101, 1'b0, 'h234, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b1, 'h100, 1'b0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 14'h0000, 24'hFFFFF0, 32'h0,    1'b0, 'h100, 1'b1};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 14'h0000, 24'h000000, 32'h03FC, 1'b1, 'h3FC, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b1, 'h000, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b0, 'h000, 1'b0};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 14'h0000, 24'h000000, 32'h0,    1'b0, 'h000, 1'b0};

        mPc = 0; mPendPc = 0; mPend = 0; mBoot = 1;
        reset = 1'b1; update_en = 1'b0; select_pc = 2'd0; branch_taken = 1'b0;
        imm_14bit = '0; imm_24bit = '0; reg_rb_data = '0; fetch_ready = 1'b1;

        // Two reset cycles. Afterwards the BOOT cycle should be showing.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        checkState("boot", 'h000, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("run0", 'h000, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("run1", 'h004, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("run2", 'h008, 0, 1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, vecs[i].ue, vecs[i].sel, vecs[i].tk, vecs[i].i14,
                          vecs[i].i24, vecs[i].rb, vecs[i].rdy);
            checkState($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expPend, 1);
        end

        // A redirect issued during BOOT is buffered, then taken on the first advance.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 3, 0, 0, 0, 32'h80, 1);
        checkState("bootRedir", 'h000, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("bootRedirTaken", 'h080, 0, 1);

        // A stall redirect to pc=0x020 jumps to 0x040 once fetch_ready returns.
        applyStimulus(0, 1, 3, 0, 0, 0, 32'h20, 1);
        applyStimulus(0, 1, 2, 0, 0, 24'h000010, 0, 0);
        checkState("stallJump", 'h020, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("stallJumpTaken", 'h040, 0, 1);

        // Reset while a redirect is buffered discards the buffered target.
        applyStimulus(0, 1, 2, 0, 0, 24'h000040, 0, 0);
        checkState("prePendReset", 'h040, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        checkState("pendReset", 'h000, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("pendResetRun", 'h000, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkState("pendResetSeq", 'h004, 0, 1);

        // Randomized traffic checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                          2'($urandom_range(0, 3)), $urandom_range(0, 1),
                          14'($urandom), 24'($urandom), $urandom,
                          ($urandom_range(0, 2) != 0));
            checkState($sformatf("rand%0d", i), mPc, mPend, !mBoot);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
